// File: rtl/seg_scan_driver.sv
// Double-buffered 8-digit seven-segment scan driver (digit1/digit2/tube_sel).
// Optional build macro SEG_DIM_EN gates tube_sel with a brightness-controlled duty window.
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] frame_data,
  input  logic [7:0]  frame_dot,
  input  logic [7:0]  frame_blank,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [2:0]  brightness,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  tube_sel
);

  // state    | meaning
  // ST_EMPTY | pending buffer free, frame_ready high
  // ST_FULL  | frame held, waiting for scan wrap (or disable) to commit
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} pend_state_t;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

  pend_state_t      r_state, w_state_nxt;
  logic             w_accept, w_commit, w_wrap, w_slot_last;
  logic [CNT_W-1:0] r_slot;
  logic [1:0]       r_pos;
  logic [31:0]      r_pend_data, r_disp_data;
  logic [7:0]       r_pend_dot, r_pend_blank, r_disp_dot, r_disp_blank;
  logic [7:0]       w_seg_lo, w_seg_hi, w_sel;

  function automatic logic [7:0] seg_of(input logic [3:0] nib, input logic dot,
                                        input logic blank);
    logic [7:0] seg;
    seg = 8'h00;
    case (nib)
      4'h0: seg = 8'hFC;  4'h1: seg = 8'h60;  4'h2: seg = 8'hDA;  4'h3: seg = 8'hF2;
      4'h4: seg = 8'h66;  4'h5: seg = 8'hB6;  4'h6: seg = 8'hBE;  4'h7: seg = 8'hE0;
      4'h8: seg = 8'hFE;  4'h9: seg = 8'hF6;  4'hA: seg = 8'hEE;  4'hB: seg = 8'h3E;
      4'hC: seg = 8'h9C;  4'hD: seg = 8'h7A;  4'hE: seg = 8'h9E;  4'hF: seg = 8'h8E;
      default: seg = 8'h00;
    endcase
    return blank ? 8'h00 : (seg | {7'b0, dot});
  endfunction

  assign w_slot_last = (r_slot == SLOT_LAST);
  assign w_wrap      = enable && (r_pos == 2'd3) && w_slot_last;
  assign frame_ready = (r_state == ST_EMPTY);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_EMPTY: if (frame_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_FULL;
      end
      ST_FULL: if (!enable || w_wrap) begin
        w_commit    = 1'b1;
        w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_EMPTY;
      r_pend_data  <= 32'h0;
      r_pend_dot   <= 8'h00;
      r_pend_blank <= 8'hFF;
      r_disp_data  <= 32'h0;
      r_disp_dot   <= 8'h00;
      r_disp_blank <= 8'hFF;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pend_data  <= frame_data;
        r_pend_dot   <= frame_dot;
        r_pend_blank <= frame_blank;
      end
      if (w_commit) begin
        r_disp_data  <= r_pend_data;
        r_disp_dot   <= r_pend_dot;
        r_disp_blank <= r_pend_blank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot <= '0;
      r_pos  <= 2'd0;
    end else if (!enable) begin
      r_slot <= '0;
      r_pos  <= 2'd0;
    end else if (w_slot_last) begin
      r_slot <= '0;
      r_pos  <= r_pos + 2'd1;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  assign w_seg_lo = seg_of(r_disp_data[{1'b0, r_pos, 2'b00} +: 4],
                           r_disp_dot[{1'b0, r_pos}], r_disp_blank[{1'b0, r_pos}]);
  assign w_seg_hi = seg_of(r_disp_data[{1'b1, r_pos, 2'b00} +: 4],
                           r_disp_dot[{1'b1, r_pos}], r_disp_blank[{1'b1, r_pos}]);
  assign w_sel    = {4'b0001 << r_pos, 4'b0001 << r_pos};

`ifdef SEG_DIM_EN
  localparam int DW = CNT_W + 4;
  logic [DW-1:0] r_duty, w_duty_nxt;
  logic          w_in_window;

  assign w_duty_nxt  = DW'(((32'(brightness) + 32'd1) * 32'(SCAN_DIV)) / 32'd8);
  assign w_in_window = ({4'b0000, r_slot} < r_duty);

  // Window is re-sampled only when the position changes (or while idle) so it stays fixed per slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_duty <= DW'(SCAN_DIV);
    else if (!enable || w_slot_last) r_duty <= w_duty_nxt;
  end
`else
  logic w_in_window;
  logic w_unused_brightness;
  assign w_in_window         = 1'b1;
  assign w_unused_brightness = ^brightness;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit1   <= 8'h00;
      digit2   <= 8'h00;
      tube_sel <= 8'h00;
    end else if (!enable) begin
      digit1   <= 8'h00;
      digit2   <= 8'h00;
      tube_sel <= 8'h00;
    end else begin
      digit1   <= w_seg_lo;
      digit2   <= w_seg_hi;
      tube_sel <= w_in_window ? w_sel : 8'h00;
    end
  end

endmodule
